// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, framing constants and width helper for the I2C write master
package i2c_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_BIT, ST_STOP} i2c_state_t;
   localparam int I2C_BITS_PER_BYTE = 9;
   localparam int I2C_QUARTERS = 4;
   function automatic int nb_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction
endpackage

// File: rtl/i2c_qtick.sv
// i2c_qtick: quarter-SCL-period tick generator, held at zero while disabled
module i2c_qtick
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic en,
   output logic qt
);
   localparam int CW = $clog2(CLK_DIV + 1);
   logic [CW-1:0] cnt;
   assign qt = en && (cnt == CW'(CLK_DIV - 1));
   always_ff @(posedge CLK) begin
      if (RST || !en) cnt <= '0;
      else cnt <= qt ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/i2c_wr_master.sv
// i2c_wr_master: START, address byte, payload bytes, STOP; aborts to STOP on any NACK
module i2c_wr_master
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h1A,
   parameter int         NBYTES   = 2,
   parameter int         CLK_DIV  = 4
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          start,
   input  logic [nb_width(NBYTES)-1:0]   nbytes,
   input  logic [8*NBYTES-1:0]           data,
   output logic                          busy,
   output logic                          done,
   output logic                          ack_err,
   inout  wire                           sda,
   output wire                           sclk
);
   localparam int NW = nb_width(NBYTES);
   localparam int SW = 8 * (NBYTES + 1);
   localparam logic [1:0] QL = 2'(I2C_QUARTERS - 1);
   localparam logic [3:0] BL = 4'(I2C_BITS_PER_BYTE - 1);
   i2c_state_t state, state_n;
   logic [1:0] phase, phase_n;
   logic [3:0] bcnt, bcnt_n;
   logic [NW-1:0] idx, idx_n, nb_l, nb_n;
   logic [SW-1:0] sh, sh_n;
   logic sda_low, scl_low, sda_low_n, scl_low_n;
   logic qt, accept;
   assign busy = state != ST_IDLE;
   assign accept = (state == ST_IDLE) && start && !done;
   assign sda = sda_low ? 1'b0 : 1'bz;
   assign sclk = scl_low ? 1'b0 : 1'bz;
   i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
      .CLK (CLK),
      .RST (RST),
      .en  (busy),
      .qt  (qt)
   );
   always_comb begin
      state_n = state;
      phase_n = phase;
      bcnt_n = bcnt;
      idx_n = idx;
      nb_n = nb_l;
      sh_n = sh;
      if (accept) begin
         state_n = ST_START;
         phase_n = '0;
         bcnt_n = '0;
         idx_n = '0;
         nb_n = (nbytes > NW'(NBYTES)) ? NW'(NBYTES) : nbytes;
         sh_n = {DEV_ADDR, 1'b0, data};
      end else if (qt) begin
         phase_n = phase + 2'd1;
         if (phase == QL) begin
            if (state == ST_START) begin
               state_n = ST_BIT;
               bcnt_n = '0;
            end else if (state == ST_STOP) state_n = ST_IDLE;
            else if (state == ST_BIT) begin
               if (bcnt != BL) begin
                  bcnt_n = bcnt + 4'd1;
                  sh_n = sh << 1;
               end else if (ack_err || idx == nb_l) state_n = ST_STOP;
               else begin
                  idx_n = idx + NW'(1);
                  bcnt_n = '0;
               end
            end
         end
      end
   end
   // pin levels for the phase about to begin; loaded only on qt
   always_comb begin
      sda_low_n = 1'b0;
      scl_low_n = 1'b0;
      case (state_n)
         ST_START: begin
            sda_low_n = phase_n != 2'd0;
            scl_low_n = phase_n[1];
         end
         ST_BIT: begin
            sda_low_n = (bcnt_n != BL) && !sh_n[SW-1];
            scl_low_n = (phase_n == 2'd0) || (phase_n == QL);
         end
         ST_STOP: begin
            sda_low_n = !phase_n[1];
            scl_low_n = phase_n == 2'd0;
         end
         default: ;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
         phase <= '0;
         bcnt <= '0;
         idx <= '0;
         nb_l <= '0;
         sh <= '0;
         sda_low <= 1'b0;
         scl_low <= 1'b0;
         done <= 1'b0;
         ack_err <= 1'b0;
      end else begin
         state <= state_n;
         phase <= phase_n;
         bcnt <= bcnt_n;
         idx <= idx_n;
         nb_l <= nb_n;
         sh <= sh_n;
         done <= qt && (state == ST_STOP) && (phase == QL);
         if (accept) ack_err <= 1'b0;
         else if (qt && state == ST_BIT && bcnt == BL && phase == 2'd2 && sda) ack_err <= 1'b1;
         if (qt) begin
            sda_low <= sda_low_n;
            scl_low <= scl_low_n;
         end
      end
   end
endmodule

// File: tb/tb_i2c_wr_master.sv
// tb_i2c_wr_master: directed bench with pull-ups, a bus monitor and an ACKing slave model
module tb_i2c_wr_master;
   logic CLK = 1'b0, RST = 1'b1, start = 1'b1;
   logic [1:0] nbytes = '0;
   logic [15:0] data = '0;
   logic busy, done, ack_err;
   wire sda_w, scl_w;
   logic slave_low = 1'b0;
   int n_checks = 0, n_errors = 0, cyc = 0;
   int nack_at = -1;
   bit absent = 1'b0;
   int n_start = 0, n_stop = 0, nbit = 0, byte_i = 0;
   logic [7:0] sh = '0;
   logic [7:0] got[$];
   logic ackq[$];
   logic p_scl = 1'b1, p_sda = 1'b1;
   int acc;

   pullup (sda_w);
   pullup (scl_w);
   assign sda_w = slave_low ? 1'b0 : 1'bz;

   i2c_wr_master #(.DEV_ADDR(7'h1A), .NBYTES(2), .CLK_DIV(2)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .start   (start),
      .nbytes  (nbytes),
      .data    (data),
      .busy    (busy),
      .done    (done),
      .ack_err (ack_err),
      .sda     (sda_w),
      .sclk    (scl_w)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // bus monitor and slave: START/STOP detection, bit capture on SCL rise, ACK drive from SCL fall
   always @(negedge CLK) begin
      if (p_scl && scl_w && p_sda && !sda_w) begin
         n_start++;
         nbit = 0;
         byte_i = 0;
      end else if (p_scl && scl_w && !p_sda && sda_w) n_stop++;
      if (!p_scl && scl_w) begin
         if (nbit < 8) begin
            sh = {sh[6:0], sda_w};
            nbit++;
         end else begin
            got.push_back(sh);
            ackq.push_back(sda_w);
            nbit = 0;
            byte_i++;
         end
      end
      if (p_scl && !scl_w) slave_low = (nbit == 8) && !absent && (byte_i != nack_at);
      p_scl = scl_w;
      p_sda = sda_w;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      got.delete();
      ackq.delete();
      n_start = 0;
      n_stop = 0;
   endtask

   task automatic launch(input logic [1:0] nb, input logic [15:0] d, output int a);
      @(negedge CLK);
      start = 1'b1;
      nbytes = nb;
      data = d;
      a = cyc + 1;
      @(negedge CLK);
      start = 1'b0;
      check("busy_after_accept", {31'd0, busy}, 1);
   endtask

   task automatic wait_done(input int a, input int lat, input string tag);
      int k = 0;
      while (!done && k < 1000) begin
         @(negedge CLK);
         k++;
      end
      check({tag, "_latency"}, cyc - a, lat);
      check({tag, "_busy_at_done"}, {31'd0, busy}, 0);
   endtask

   task automatic check_bus(input int n, input logic [23:0] bytes, input logic [2:0] acks, input string tag);
      check({tag, "_nbytes"}, got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++) begin
         check({tag, "_byte"}, {24'd0, got[i]}, {24'd0, bytes[23-8*i -: 8]});
         check({tag, "_ack"}, {31'd0, ackq[i]}, {31'd0, acks[2-i]});
      end
      check({tag, "_starts"}, n_start, 1);
      check({tag, "_stops"}, n_stop, 1);
   endtask

   initial begin
      repeat (3) @(negedge CLK);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_sda", {31'd0, sda_w}, 1);
      check("rst_scl", {31'd0, scl_w}, 1);
      RST = 1'b0;
      start = 1'b0;
      @(negedge CLK);
      check("post_rst_busy", {31'd0, busy}, 0);
      check("post_rst_sda", {31'd0, sda_w}, 1);
      check("post_rst_scl", {31'd0, scl_w}, 1);

      clear_mon();
      launch(2'd2, 16'h1E00, acc);
      wait_done(acc, 232, "s2");
      @(negedge CLK);
      check("s2_done_pulse", {31'd0, done}, 0);
      check_bus(3, 24'h341E00, 3'b000, "s2");
      check("s2_ack_err", {31'd0, ack_err}, 0);

      clear_mon();
      nack_at = 1;
      launch(2'd2, 16'h1E00, acc);
      wait_done(acc, 160, "s3");
      @(negedge CLK);
      check_bus(2, 24'h341E00, 3'b010, "s3");
      check("s3_ack_err", {31'd0, ack_err}, 1);

      clear_mon();
      nack_at = -1;
      absent = 1'b1;
      launch(2'd0, 16'hABCD, acc);
      wait_done(acc, 88, "s4");
      @(negedge CLK);
      check_bus(1, 24'h340000, 3'b100, "s4");
      check("s4_ack_err", {31'd0, ack_err}, 1);

      clear_mon();
      launch(2'd0, 16'h1234, acc);
      repeat (20) @(negedge CLK);
      start = 1'b1;
      nbytes = 2'd2;
      data = 16'hFFFF;
      @(negedge CLK);
      start = 1'b0;
      check("s5_busy_mid", {31'd0, busy}, 1);
      wait_done(acc, 88, "s5a");
      start = 1'b1;
      nbytes = 2'd2;
      data = 16'h1E00;
      absent = 1'b0;
      @(negedge CLK);
      check("s5_no_accept_on_done", {31'd0, busy}, 0);
      check("s5_ack_err_held", {31'd0, ack_err}, 1);
      clear_mon();
      acc = cyc + 1;
      @(negedge CLK);
      start = 1'b0;
      check("s5_accept_next", {31'd0, busy}, 1);
      check("s5_ack_err_cleared", {31'd0, ack_err}, 0);
      wait_done(acc, 232, "s5b");
      @(negedge CLK);
      check_bus(3, 24'h341E00, 3'b000, "s5b");

      clear_mon();
      launch(2'd2, 16'h1E00, acc);
      for (int k = 0; k < 1000 && !(byte_i == 1 && nbit == 5); k++) @(negedge CLK);
      check("s6_reached_bit5", byte_i * 16 + nbit, 16 + 5);
      RST = 1'b1;
      @(negedge CLK);
      check("s6_busy", {31'd0, busy}, 0);
      check("s6_done", {31'd0, done}, 0);
      check("s6_sda", {31'd0, sda_w}, 1);
      check("s6_scl", {31'd0, scl_w}, 1);
      RST = 1'b0;
      @(negedge CLK);
      clear_mon();
      launch(2'd3, 16'h1E00, acc);
      wait_done(acc, 232, "s6");
      @(negedge CLK);
      check_bus(3, 24'h341E00, 3'b000, "s6");
      check("s6_ack_err", {31'd0, ack_err}, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
